// File: rtl/sreg_sipo_rx.sv
// Serial-in, parallel-out deserializer: receive end of the shift-register
// serial link. Reassembles WIDTH-bit words from a single-bit stream and
// presents each completed word through a valid/ready holding register,
// with a sticky overrun flag for words that replace an unconsumed one.
module sreg_sipo_rx #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int SYNC_MODE = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             frame_start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_q;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] shift_nxt;
    logic [WIDTH-1:0] shift_fresh;
    logic             word_done;

    // Insert one bit at the end of the register that the bit order dictates,
    // so the first bit of a word finishes in dout[WIDTH-1] (MSB first) or dout[0].
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                   input logic             b);
        if (MSB_FIRST != 0)
            return {cur[WIDTH-2:0], b};
        else
            return {b, cur[WIDTH-1:1]};
    endfunction

    // Candidate register contents and word-completion detect for this edge;
    // a frame_start restarts the word, so it never completes one.
    always_comb begin
        shift_nxt   = shift_in(shift_q, sin);
        shift_fresh = shift_in('0, sin);
        word_done   = sin_en && !frame_start && (state == SHIFT) && (cnt == CNT_LAST);
    end

    // Receive FSM, bit counter, output holding register and overrun flag.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= (SYNC_MODE != 0) ? IDLE : SHIFT;
            shift_q    <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (sin_en) begin
                if (frame_start) begin
                    // New word boundary: any partial word is dropped silently.
                    shift_q <= shift_fresh;
                    cnt     <= CNT_ONE;
                    state   <= SHIFT;
                end else if (state == SHIFT) begin
                    shift_q <= shift_nxt;
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= (SYNC_MODE != 0) ? IDLE : SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            // Newest word always wins the holding register; completion keeps
            // dout_valid high even when the old word is consumed on this edge.
            if (word_done) begin
                dout       <= shift_nxt;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            // Set has priority over clear.
            if (word_done && dout_valid && !dout_ready)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

    // A word is in progress once at least one of its bits has been taken.
    assign busy = (state == SHIFT) && (cnt != '0);

endmodule

// File: doc/sreg_sipo_rx.md
Name: sreg_sipo_rx

Overview:
- Serial-in, parallel-out deserializer.
- It is the receive end of the shift-register serial link. It reassembles WIDTH-bit words from the single-bit stream produced by the parallel-in/serial-out transmitter.
- Each completed word goes into an output holding register with a valid/ready handshake, so reception continues while downstream drains the word.
- A sticky overrun flag reports words that arrive before the previous word was consumed.

Parameters:
- WIDTH, 8: word length in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in dout[WIDTH-1]; 0 = first received bit lands in dout[0].
- SYNC_MODE, 1: 1 = bits are ignored until frame_start marks a word boundary; 0 = free-running, any accepted bit may start a word.

Ports:
- sys_clk, input, 1: system clock; all state updates on its rising edge.
- sys_rst, input, 1: synchronous, active-high reset.
- sin, input, 1: serial data bit.
- sin_en, input, 1: sin is accepted on a rising edge where sin_en=1.
- frame_start, input, 1: qualified by sin_en; marks the accepted bit as bit 0 of a new word.
- dout, output, WIDTH: last completed word.
- dout_valid, output, 1: dout holds an unconsumed word.
- dout_ready, input, 1: downstream consumes dout on an edge where dout_valid=1 and dout_ready=1.
- overrun, output, 1: sticky; a completed word was lost.
- overrun_clr, input, 1: clears overrun.
- busy, output, 1: a word is partially received (state SHIFT).

Behaviour:
- Reset (sys_rst=1 at an edge): shift register = 0, bit counter = 0, dout = 0, dout_valid = 0, overrun = 0, busy = 0. State goes to IDLE when SYNC_MODE=1 and to SHIFT when SYNC_MODE=0.
- Reset mid-word discards the partial word and any pending dout.
- Reset has priority over every other input.
- FSM states: IDLE and SHIFT.
- IDLE (SYNC_MODE=1 only):
  - Accepted bits without frame_start are ignored.
  - An accepted bit with frame_start stores the bit, sets counter = 1 and moves to SHIFT.
- SHIFT:
  - Each accepted bit shifts into the register and increments the counter.
  - With MSB_FIRST=1: shift = {shift[WIDTH-2:0], sin}.
  - With MSB_FIRST=0: shift = {sin, shift[WIDTH-1:1]}.
- frame_start while in SHIFT: the partial word is discarded without any flag, the counter is set to 1 with the new bit as bit 0, and the state stays SHIFT.
- Word completion: the edge that accepts the WIDTH-th bit (counter = WIDTH-1 before the edge) loads the assembled word, including that bit, into dout and sets dout_valid=1 at that same edge. Latency is 0 cycles after the last bit edge.
- After completion:
  - The counter returns to 0.
  - State goes to IDLE if SYNC_MODE=1, else stays SHIFT with counter 0.
  - busy is 1 when in SHIFT with counter != 0, or when in SHIFT with SYNC_MODE=0 after at least one accepted bit of the current word.
- Handshake:
  - dout_valid clears on an edge with dout_valid=1 and dout_ready=1, unless a new word completes on that same edge.
  - dout is stable while dout_valid=1, except on overrun.
- Simultaneous consume and completion: the new word loads, dout_valid stays 1, and no overrun is flagged.
- Overrun:
  - Condition: a word completes while dout_valid=1 and dout_ready=0.
  - The new word overwrites dout (newest wins), dout_valid stays 1 and overrun is set.
- overrun_clr clears overrun at the next edge. If overrun_clr and a new overrun coincide, overrun stays 1 (set wins).
- sin_en=0 holds all receive state; the handshake still operates.
- Counter width is clog2(WIDTH+1). The counter never exceeds WIDTH-1 at rest.

Test Plan:
- Basic MSB-first word: WIDTH=8, MSB_FIRST=1, SYNC_MODE=1. Release reset, then send 0,1,1,0,1,1,0,1 with sin_en=1 on consecutive edges and frame_start on the first bit only. Required: dout=8'b0110_1101 and dout_valid=1 at the 8th edge; busy=1 during bits 1-7; overrun=0.
- Gapped stream, LSB-first: MSB_FIRST=0, the same 8 bits, with sin_en deasserted for 3 cycles between bits 4 and 5. Required: dout=8'b1011_0110, and completion occurs only on the edge accepting the 8th bit.
- Resync mid-word: send 5 bits, then assert frame_start with 8 new bits 1111_0000. Required: the single completion gives dout=8'hF0, no extra dout_valid pulse, overrun=0.
- Backpressure: hold dout_ready=0 and receive 8'h6D then 8'hA5. Required: dout=8'hA5, dout_valid=1, overrun=1. Then pulse overrun_clr: overrun=0 and dout_valid still 1.
- Same-edge consume: assert dout_ready exactly on the edge completing a second word. Required: dout takes the new word, dout_valid stays 1, overrun=0.
- Reset mid-operation: assert sys_rst after 4 bits with a word pending. Required: next cycle dout=0, dout_valid=0, busy=0. A subsequent full frame 8'h6D completes normally.
